// File: rtl/icache_fetch_pkg.sv
// icache_fetch_pkg: shared word size, FSM encodings and default geometry for the fetch cache.
package icache_fetch_pkg;
  localparam int WORD_SIZE = 16;
  localparam int ICACHE_INDEX_BITS = 2;
  localparam int ICACHE_OFFSET_BITS = 2;
  localparam logic [0:0] ICACHE_IDLE = 1'b0;
  localparam logic [0:0] ICACHE_REFILL = 1'b1;
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: valid/tag/data storage with combinational read by index.
// Valid bits clear on reset; tag and data are left unreset.
module icache_line_array
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int OFFSET_BITS = ICACHE_OFFSET_BITS,
  parameter int TAG_BITS = WORD_SIZE - INDEX_BITS - OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [INDEX_BITS-1:0]  i_rd_idx,
  input  logic [OFFSET_BITS-1:0] i_rd_off,
  output logic                   o_rd_valid,
  output logic [TAG_BITS-1:0]    o_rd_tag,
  output logic [WORD_SIZE-1:0]   o_rd_data,
  input  logic                   i_wr_word,
  input  logic [INDEX_BITS-1:0]  i_wr_idx,
  input  logic [OFFSET_BITS-1:0] i_wr_off,
  input  logic [WORD_SIZE-1:0]   i_wr_data,
  input  logic                   i_val_we,
  input  logic [INDEX_BITS-1:0]  i_val_idx,
  input  logic                   i_val_d,
  input  logic                   i_tag_we,
  input  logic [TAG_BITS-1:0]    i_wr_tag
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;
  logic [LINES-1:0]     r_valid;
  logic [TAG_BITS-1:0]  r_tag  [LINES];
  logic [WORD_SIZE-1:0] r_data [LINES][WORDS];
  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx][i_rd_off];
  always_ff @(posedge clk) begin
    if (reset_n) r_valid <= '0;
    else if (i_val_we) r_valid[i_val_idx] <= i_val_d;
  end
  always_ff @(posedge clk) begin
    if (i_wr_word) r_data[i_wr_idx][i_wr_off] <= i_wr_data;
    if (i_tag_we) r_tag[i_wr_idx] <= i_wr_tag;
  end
endmodule

// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped instruction cache; hits answer same cycle, misses refill a line word by word.
// Define ICACHE_STATS_EN to add the num_hit/num_miss counters.
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int OFFSET_BITS = ICACHE_OFFSET_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM1,
  input  logic [WORD_SIZE-1:0] address1,
  output logic [WORD_SIZE-1:0] data1,
  output logic                 i_ready,
  output logic                 mem_readM1,
  output logic [WORD_SIZE-1:0] mem_address1,
  input  logic [WORD_SIZE-1:0] mem_data1,
  input  logic                 mem_ready1
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]          num_hit,
  output logic [15:0]          num_miss
`endif
);
  localparam int TAG_BITS = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
  logic [0:0]             r_state;
  logic [TAG_BITS-1:0]    r_tag;
  logic [INDEX_BITS-1:0]  r_idx;
  logic [OFFSET_BITS-1:0] r_cnt;
  logic                   w_valid;
  logic [TAG_BITS-1:0]    w_rd_tag;
  logic [WORD_SIZE-1:0]   w_rd_data;
  logic [TAG_BITS-1:0]    w_tag;
  logic [INDEX_BITS-1:0]  w_idx;
  logic [OFFSET_BITS-1:0] w_off;
  logic                   w_idle, w_match, w_hit, w_miss, w_fill, w_last;
  assign w_off   = address1[OFFSET_BITS-1:0];
  assign w_idx   = address1[OFFSET_BITS +: INDEX_BITS];
  assign w_tag   = address1[WORD_SIZE-1 -: TAG_BITS];
  assign w_idle  = r_state == ICACHE_IDLE;
  assign w_match = w_valid && (w_rd_tag == w_tag);
  assign w_hit   = w_idle && readM1 && w_match;
  assign w_miss  = w_idle && readM1 && !w_match;
  assign w_fill  = !w_idle && mem_ready1;
  assign w_last  = w_fill && (r_cnt == '1);
  assign i_ready      = w_hit;
  assign data1        = w_hit ? w_rd_data : '0;
  assign mem_readM1   = !w_idle;
  assign mem_address1 = w_idle ? '0 : {r_tag, r_idx, r_cnt};
  // The line goes invalid on miss entry so a partial refill can never hit.
  icache_line_array #(.INDEX_BITS(INDEX_BITS), .OFFSET_BITS(OFFSET_BITS)) u_lines (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_rd_idx  (w_idx),
    .i_rd_off  (w_off),
    .o_rd_valid(w_valid),
    .o_rd_tag  (w_rd_tag),
    .o_rd_data (w_rd_data),
    .i_wr_word (w_fill),
    .i_wr_idx  (r_idx),
    .i_wr_off  (r_cnt),
    .i_wr_data (mem_data1),
    .i_val_we  (w_miss || w_last),
    .i_val_idx (w_miss ? w_idx : r_idx),
    .i_val_d   (w_last),
    .i_tag_we  (w_last),
    .i_wr_tag  (r_tag)
  );
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state <= ICACHE_IDLE;
      r_tag   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else if (w_miss) begin
      r_state <= ICACHE_REFILL;
      r_tag   <= w_tag;
      r_idx   <= w_idx;
      r_cnt   <= '0;
    end else if (w_fill) begin
      r_cnt   <= r_cnt + 1'b1;
      r_state <= w_last ? ICACHE_IDLE : ICACHE_REFILL;
    end
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset_n) begin
      num_hit  <= '0;
      num_miss <= '0;
    end else begin
      if (w_hit) num_hit <= num_hit + 16'd1;
      if (w_miss) num_miss <= num_miss + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_fetch.sv
// tb_icache_fetch: scoreboard bench; refill addresses are queued when a fetch is issued and checked by the memory model.
module tb_icache_fetch;
  localparam int L = 2;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        readM1 = 1'b0;
  logic [15:0] address1 = '0;
  logic [15:0] data1, mem_address1;
  logic [15:0] mem_data1 = '0;
  logic        i_ready, mem_readM1;
  logic        mem_ready1 = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [15:0] num_hit, num_miss;
`endif
  int n_vec = 0;
  int n_err = 0;
  int lat = 0;
  int hs_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e_addr;

  always #5 clk = ~clk;

  icache_fetch dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .readM1      (readM1),
    .address1    (address1),
    .data1       (data1),
    .i_ready     (i_ready),
    .mem_readM1  (mem_readM1),
    .mem_address1(mem_address1),
    .mem_data1   (mem_data1),
    .mem_ready1  (mem_ready1)
`ifdef ICACHE_STATS_EN
    ,
    .num_hit     (num_hit),
    .num_miss    (num_miss)
`endif
  );

  // Memory with L cycles per word; each completed word is checked against the queued refill address.
  always @(negedge clk) begin
    if (mem_readM1) begin
      if (lat == L - 1) begin
        mem_ready1 = 1'b1;
        mem_data1 = 16'hA000 + mem_address1;
        lat = 0;
        hs_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL mem_req got addr=%h required none", mem_address1);
        end else begin
          e_addr = exp_q.pop_front();
          if (mem_address1 !== e_addr) begin
            n_err++;
            $display("FAIL mem_addr got %h required %h", mem_address1, e_addr);
          end
        end
      end else begin
        mem_ready1 = 1'b0;
        lat++;
      end
    end else begin
      mem_ready1 = 1'b0;
      lat = 0;
    end
  end

  task automatic push_line(input logic [15:0] base);
    for (int i = 0; i < 4; i++) exp_q.push_back(base + 16'(i));
  endtask

  task automatic wait_ready(output int cyc, output logic [15:0] d);
    cyc = -1;
    d = 'x;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (i_ready) begin
        cyc = k;
        d = data1;
        break;
      end
    end
  endtask

  task automatic fetch(input logic [15:0] a, output int cyc, output logic [15:0] d);
    @(posedge clk);
    #1 readM1 = 1'b1;
    address1 = a;
    wait_ready(cyc, d);
    @(posedge clk);
    #1 readM1 = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    readM1 = 1'b0;
    address1 = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec++;
    if ({i_ready, mem_readM1, data1, mem_address1} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_outputs got rdy=%b mreq=%b d=%h ma=%h required all 0", i_ready, mem_readM1, data1, mem_address1);
    end
`ifdef ICACHE_STATS_EN
    n_vec++;
    if (num_hit !== 16'd0 || num_miss !== 16'd0) begin
      n_err++;
      $display("FAIL reset_stats got hit=%0d miss=%0d required 0 0", num_hit, num_miss);
    end
`endif
  endtask

  task automatic test_cold_miss();
    int cyc;
    logic [15:0] d;
    push_line(16'h0000);
    fetch(16'h0000, cyc, d);
    n_vec++;
    if (cyc !== 9 || d !== 16'hA000) begin
      n_err++;
      $display("FAIL cold_miss got lat=%0d d=%h required lat=9 d=a000", cyc, d);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL cold_miss_words got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_hits();
    int cyc;
    logic [15:0] d;
    for (int a = 1; a < 4; a++) begin
      fetch(16'(a), cyc, d);
      n_vec++;
      if (cyc !== 0 || d !== 16'hA000 + 16'(a)) begin
        n_err++;
        $display("FAIL hit_%0d got lat=%0d d=%h required lat=0 d=%h", a, cyc, d, 16'hA000 + 16'(a));
      end
    end
    @(posedge clk);
    #1 address1 = 16'h0001;
    readM1 = 1'b0;
    @(negedge clk);
    n_vec++;
    if (i_ready !== 1'b0 || data1 !== 16'h0000) begin
      n_err++;
      $display("FAIL no_request got rdy=%b d=%h required 0 0000", i_ready, data1);
    end
  endtask

  task automatic test_conflict();
    int cyc;
    logic [15:0] d;
    push_line(16'h0010);
    fetch(16'h0010, cyc, d);
    n_vec++;
    if (cyc !== 9 || d !== 16'hA010) begin
      n_err++;
      $display("FAIL evict_0010 got lat=%0d d=%h required lat=9 d=a010", cyc, d);
    end
    push_line(16'h0000);
    fetch(16'h0000, cyc, d);
    n_vec++;
    if (cyc !== 9 || d !== 16'hA000) begin
      n_err++;
      $display("FAIL evict_0000 got lat=%0d d=%h required lat=9 d=a000", cyc, d);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL conflict_words got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_refill();
    int cyc;
    int base;
    logic [15:0] d;
    do_reset();
    push_line(16'h0000);
    base = hs_cnt;
    @(posedge clk);
    #1 readM1 = 1'b1;
    address1 = 16'h0000;
    for (int k = 0; k < 50 && hs_cnt - base < 2; k++) @(posedge clk);
    #1 reset_n = 1'b1;
    readM1 = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mem_readM1 !== 1'b0 || i_ready !== 1'b0 || hs_cnt - base != 2) begin
      n_err++;
      $display("FAIL mid_reset got mreq=%b rdy=%b words=%0d required 0 0 2", mem_readM1, i_ready, hs_cnt - base);
    end
    exp_q.delete();
    push_line(16'h0000);
    fetch(16'h0000, cyc, d);
    n_vec++;
    if (cyc !== 9 || d !== 16'hA000 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL refetch_after_reset got lat=%0d d=%h left=%0d required lat=9 d=a000 left=0", cyc, d, exp_q.size());
    end
  endtask

  task automatic test_addr_change();
    int cyc;
    logic [15:0] d;
    do_reset();
    push_line(16'h0000);
    push_line(16'h0004);
    @(posedge clk);
    #1 readM1 = 1'b1;
    address1 = 16'h0000;
    repeat (3) @(posedge clk);
    #1 address1 = 16'h0004;
    wait_ready(cyc, d);
    @(posedge clk);
    #1 readM1 = 1'b0;
    n_vec++;
    if (cyc + 3 !== 18 || d !== 16'hA004) begin
      n_err++;
      $display("FAIL addr_change got lat=%0d d=%h required lat=18 d=a004", cyc + 3, d);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL addr_change_words got %0d left required 0", exp_q.size());
    end
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    int cyc;
    logic [15:0] d;
    logic [15:0] seq [5];
    seq = '{16'h0000, 16'h0001, 16'h0002, 16'h0010, 16'h0000};
    do_reset();
    push_line(16'h0000);
    push_line(16'h0010);
    push_line(16'h0000);
    for (int i = 0; i < 5; i++) fetch(seq[i], cyc, d);
    @(negedge clk);
    n_vec++;
    if (num_miss !== 16'd3 || num_hit !== 16'd5) begin
      n_err++;
      $display("FAIL stats got hit=%0d miss=%0d required 5 3", num_hit, num_miss);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_reset_mid_refill();
    test_addr_change();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
